// File: rtl/mbc_control_sequencer.sv
// Instruction-cycle controller for the MBC datapath: owns the sequence counter,
// the one-hot T0..T7 timing and the fetch/decode/indirect/execute strobes.
module mbc_control_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RUN,
    input  logic [7:0] DECODED_SIGNAL,
    input  logic       I_BIT,
    input  logic       HLT_REQ,
    input  logic       MEM_ACK,
    output logic [7:0] T,
    output logic [2:0] SC,
    output logic       AR_LD,
    output logic       IR_LD,
    output logic       PC_INC,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       EXEC_EN,
    output logic       HALTED,
    output logic       ERROR,
    output logic [1:0] state_dbg
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sc_q, sc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [7:0]    d_q;
    logic          i_q;

    logic d_onehot;
    logic step, end_instr, go_halt, go_err, expire, mem_req;

    // Handshake: MEM_RD/MEM_WR is a level held until the cycle in which MEM_ACK
    // is seen high; that cycle completes the transfer and SC advances on the
    // following edge. MEM_ACK with no request pending has no effect.
    assign d_onehot = (DECODED_SIGNAL != 8'd0) &&
                      ((DECODED_SIGNAL & (DECODED_SIGNAL - 8'd1)) == 8'd0);

    assign T         = (state_q == S_RUNNING) ? (8'd1 << sc_q) : 8'd0;
    assign SC        = sc_q;
    assign HALTED    = (state_q == S_HALTED);
    assign ERROR     = err_q;
    assign state_dbg = state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sc_q    <= 3'd0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            d_q     <= 8'd0;
            i_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            if (state_q == S_RUNNING && sc_q == 3'd2) begin
                d_q <= DECODED_SIGNAL;
                i_q <= I_BIT;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        tmo_d     = '0;
        err_d     = err_q;
        AR_LD     = 1'b0;
        IR_LD     = 1'b0;
        PC_INC    = 1'b0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        EXEC_EN   = 1'b0;
        step      = 1'b0;
        end_instr = 1'b0;
        go_halt   = 1'b0;
        go_err    = 1'b0;
        expire    = 1'b0;
        mem_req   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    state_d = S_RUNNING;
                    sc_d    = 3'd0;
                end
            end
            S_RUNNING: begin
                case (sc_q)
                    3'd0: begin
                        AR_LD = 1'b1;
                        step  = 1'b1;
                    end
                    3'd1: begin
                        MEM_RD = 1'b1;
                        if (MEM_ACK) begin
                            IR_LD  = 1'b1;
                            PC_INC = 1'b1;
                            step   = 1'b1;
                        end
                    end
                    3'd2: begin
                        AR_LD  = 1'b1;
                        step   = 1'b1;
                        go_err = !d_onehot;
                    end
                    3'd3: begin
                        if (d_q[7]) begin
                            EXEC_EN   = 1'b1;
                            end_instr = 1'b1;
                            go_halt   = HLT_REQ;
                        end else if (i_q) begin
                            MEM_RD = 1'b1;
                            if (MEM_ACK) begin
                                AR_LD = 1'b1;
                                step  = 1'b1;
                            end
                        end else begin
                            step = 1'b1;
                        end
                    end
                    3'd4: begin
                        if (d_q[3] || d_q[5]) begin
                            MEM_WR = 1'b1;
                            if (MEM_ACK) begin
                                step      = d_q[5];
                                end_instr = d_q[3];
                            end
                        end else if (d_q[4]) begin
                            EXEC_EN   = 1'b1;
                            end_instr = 1'b1;
                        end else begin
                            MEM_RD = 1'b1;
                            step   = MEM_ACK;
                        end
                    end
                    3'd5: begin
                        EXEC_EN   = 1'b1;
                        step      = d_q[6];
                        end_instr = !d_q[6];
                    end
                    3'd6: begin
                        MEM_WR    = 1'b1;
                        end_instr = MEM_ACK;
                    end
                    default: go_err = 1'b1;
                endcase

                // Wait-cycle counter: only request cycles without an ack count.
                mem_req = MEM_RD | MEM_WR;
                if (mem_req && !MEM_ACK) begin
                    if (tmo_q == TMO_LAST) begin
                        expire = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end

                if (go_err || expire) begin
                    state_d = S_HALTED;
                    sc_d    = 3'd0;
                    err_d   = 1'b1;
                end else if (go_halt) begin
                    state_d = S_HALTED;
                    sc_d    = 3'd0;
                end else if (end_instr) begin
                    sc_d    = 3'd0;
                    state_d = RUN ? S_RUNNING : S_IDLE;
                end else if (step) begin
                    sc_d = sc_q + 3'd1;
                end
            end
            S_HALTED: begin
                sc_d = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                sc_d    = 3'd0;
            end
        endcase
    end

endmodule
